// File: rtl/br_port_ctrl_pkg.sv
// Shared definitions for the BR register bank and its port controller:
// bank geometry, controller state encoding and the hardwired-zero address.
package br_port_ctrl_pkg;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  localparam logic [AW-1:0] X0_ADDR = '0;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    ACK  = 2'd2
  } state_e;

  function automatic logic is_x0(input logic [AW-1:0] addr);
    return addr == X0_ADDR;
  endfunction

endpackage

// File: rtl/br_port_ctrl.sv
// Port controller in front of BR: clears x1..x31 after reset, then shares the
// write port and the a2 read port between the core and a debug/loader master.
module br_port_ctrl
  import br_port_ctrl_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          core_we,
  input  logic [AW-1:0] core_a3,
  input  logic [DW-1:0] core_wd3,
  input  logic [AW-1:0] core_a2,
  output logic          core_stall,
  output logic          busy,
  input  logic          dbg_req,
  input  logic          dbg_wr,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  output logic          br_we,
  output logic [AW-1:0] br_a3,
  output logic [DW-1:0] br_wd3,
  output logic [AW-1:0] br_a2,
  input  logic [DW-1:0] br_rd2
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIMIT = SW'(STARVE_MAX);
  localparam logic [AW-1:0] LAST_REG     = AW'(NREG - 1);

  state_e        state;
  logic [AW-1:0] clr_cnt;
  logic [SW-1:0] starve_cnt;

  logic core_wr_ok;
  logic starved;
  logic dbg_read;
  logic dbg_write;
  logic core_wins;

  assign core_wr_ok = core_we && !is_x0(core_a3);
  assign starved    = (starve_cnt == STARVE_LIMIT);

  // NOTE: every output gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    br_we      = 1'b0;
    br_a3      = core_a3;
    br_wd3     = core_wd3;
    br_a2      = core_a2;
    core_stall = 1'b0;
    busy       = 1'b0;
    dbg_ack    = 1'b0;
    dbg_read   = 1'b0;
    dbg_write  = 1'b0;
    core_wins  = 1'b0;

    if (!rst_n) begin
      core_stall = 1'b1;
      busy       = 1'b1;
    end else begin
      case (state)
        INIT: begin
          br_we      = 1'b1;
          br_a3      = clr_cnt;
          br_wd3     = '0;
          core_stall = 1'b1;
          busy       = 1'b1;
        end
        IDLE: begin
          if (dbg_req && !dbg_wr) begin
            // Stalled instruction replays next cycle, so its write is masked.
            dbg_read   = 1'b1;
            br_a2      = dbg_addr;
            core_stall = 1'b1;
          end else if (dbg_req && dbg_wr && (!core_we || starved)) begin
            dbg_write  = 1'b1;
            br_we      = !is_x0(dbg_addr);
            br_a3      = dbg_addr;
            br_wd3     = dbg_wdata;
            core_stall = core_we;
          end else begin
            br_we     = core_wr_ok;
            core_wins = dbg_req && dbg_wr;
          end
        end
        ACK: begin
          br_we   = core_wr_ok;
          dbg_ack = 1'b1;
        end
        default: begin
          core_stall = 1'b1;
          busy       = 1'b1;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      clr_cnt    <= AW'(1);
      starve_cnt <= '0;
      dbg_rdata  <= '0;
    end else begin
      case (state)
        INIT: begin
          clr_cnt <= clr_cnt + AW'(1);
          if (clr_cnt == LAST_REG) state <= IDLE;
        end
        IDLE: begin
          if (dbg_read) begin
            dbg_rdata <= br_rd2;
            state     <= ACK;
          end else if (dbg_write) begin
            starve_cnt <= '0;
            state      <= ACK;
          end else if (core_wins) begin
            starve_cnt <= starve_cnt + SW'(1);
          end
        end
        ACK:     state <= IDLE;
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_br_port_ctrl.sv
// Directed bench for br_port_ctrl with a behavioural BR bank whose registers
// power up holding junk, so a missed clear shows up on readback.
module tb_br_port_ctrl;
  import br_port_ctrl_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          core_we = 1'b0;
  logic [AW-1:0] core_a3 = '0;
  logic [DW-1:0] core_wd3 = '0;
  logic [AW-1:0] core_a2 = '0;
  logic          core_stall, busy;
  logic          dbg_req = 1'b0;
  logic          dbg_wr = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic          dbg_ack;
  logic [DW-1:0] dbg_rdata;
  logic          br_we;
  logic [AW-1:0] br_a3;
  logic [DW-1:0] br_wd3;
  logic [AW-1:0] br_a2;
  logic [DW-1:0] br_rd2;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  br_port_ctrl #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_we(core_we), .core_a3(core_a3), .core_wd3(core_wd3), .core_a2(core_a2),
    .core_stall(core_stall), .busy(busy),
    .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .br_we(br_we), .br_a3(br_a3), .br_wd3(br_wd3), .br_a2(br_a2), .br_rd2(br_rd2)
  );

  // BR model: x0 reads 0; never-written registers read a junk pattern.
  logic [DW-1:0] br_mem [NREG];
  bit   [NREG-1:0] written;

  always @(posedge clk) begin
    if (br_we && br_a3 != '0) begin
      br_mem[br_a3]  <= br_wd3;
      written[br_a3] <= 1'b1;
    end
  end

  assign br_rd2 = (br_a2 == '0) ? '0 :
                  written[br_a2] ? br_mem[br_a2] : {16'hA5A5, 11'd0, br_a2};

  // Runs from the reset-release negedge through the first IDLE cycle.
  task automatic check_clear_sequence(input string tag);
    for (int i = 1; i <= 31; i++) begin
      dbg_req   = (i < 31);
      dbg_wr    = 1'b1;
      dbg_addr  = 5'd3;
      dbg_wdata = '1;
      if (i == 31) core_we = 1'b0;
      #1;
      tests_run++;
      if (br_we !== 1'b1 || br_a3 !== AW'(i) || br_wd3 !== '0 || busy !== 1'b1 ||
          core_stall !== 1'b1 || dbg_ack !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s cycle %0d: we=%b a3=%0d wd3=%h busy=%b stall=%b ack=%b, required 1 %0d 0 1 1 0",
                 tag, i, br_we, br_a3, br_wd3, busy, core_stall, dbg_ack, i);
      end
      @(negedge clk);
    end
    #1;
    tests_run++;
    if (busy !== 1'b0 || core_stall !== 1'b0 || br_we !== 1'b0 || dbg_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s cycle 32: busy=%b stall=%b we=%b ack=%b, required 0 0 0 0",
               tag, busy, core_stall, br_we, dbg_ack);
    end
  endtask

  task automatic test_reset();
    core_we  = 1'b1;
    core_a3  = 5'd3;
    core_wd3 = 32'hBAD0_BAD0;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (br_we !== 1'b0 || core_stall !== 1'b1 || busy !== 1'b1 || dbg_ack !== 1'b0 ||
        dbg_rdata !== '0) begin
      tests_failed++;
      $display("FAIL reset_hold: we=%b stall=%b busy=%b ack=%b rdata=%h, required 0 1 1 0 0",
               br_we, core_stall, busy, dbg_ack, dbg_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_clear_sequence("init");
  endtask

  task automatic test_dbg_write_free(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    @(negedge clk);
    core_we   = 1'b0;
    dbg_req   = 1'b1;
    dbg_wr    = 1'b1;
    dbg_addr  = addr;
    dbg_wdata = data;
    #1;
    tests_run++;
    if (br_we !== 1'b1 || br_a3 !== addr || br_wd3 !== data || core_stall !== 1'b0 ||
        dbg_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_accept x%0d: we=%b a3=%0d wd3=%h stall=%b ack=%b, required 1 %0d %h 0 0",
               addr, br_we, br_a3, br_wd3, core_stall, dbg_ack, addr, data);
    end
    @(negedge clk);
    dbg_req = 1'b0;
    #1;
    tests_run++;
    if (dbg_ack !== 1'b1 || br_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_ack x%0d: ack=%b we=%b, required 1 0", addr, dbg_ack, br_we);
    end
  endtask

  task automatic test_dbg_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp,
                               input string tag);
    @(negedge clk);
    core_we   = 1'b1;
    core_a3   = 5'd4;
    core_wd3  = 32'h4444_4444;
    core_a2   = addr ^ 5'h1f;
    dbg_req   = 1'b1;
    dbg_wr    = 1'b0;
    dbg_addr  = addr;
    #1;
    tests_run++;
    if (core_stall !== 1'b1 || br_a2 !== addr || br_we !== 1'b0 || dbg_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s accept: stall=%b a2=%0d we=%b ack=%b, required 1 %0d 0 0",
               tag, core_stall, br_a2, br_we, dbg_ack, addr);
    end
    @(negedge clk);
    core_we = 1'b0;
    dbg_req = 1'b0;
    #1;
    tests_run++;
    if (dbg_ack !== 1'b1 || dbg_rdata !== exp || core_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s ack: ack=%b rdata=%h stall=%b, required 1 %h 0",
               tag, dbg_ack, dbg_rdata, core_stall, exp);
    end
  endtask

  task automatic test_starve(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    @(negedge clk);
    core_we   = 1'b1;
    core_a3   = 5'd7;
    core_wd3  = 32'h0000_0077;
    dbg_req   = 1'b1;
    dbg_wr    = 1'b1;
    dbg_addr  = addr;
    dbg_wdata = data;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests_run++;
      if (br_we !== 1'b1 || br_a3 !== 5'd7 || br_wd3 !== 32'h77 || core_stall !== 1'b0 ||
          dbg_ack !== 1'b0) begin
        tests_failed++;
        $display("FAIL starve x%0d core cycle %0d: we=%b a3=%0d wd3=%h stall=%b ack=%b, required 1 7 77 0 0",
                 addr, k, br_we, br_a3, br_wd3, core_stall, dbg_ack);
      end
      @(negedge clk);
    end
    #1;
    tests_run++;
    if (br_we !== 1'b1 || br_a3 !== addr || br_wd3 !== data || core_stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL starve x%0d forced: we=%b a3=%0d wd3=%h stall=%b, required 1 %0d %h 1",
               addr, br_we, br_a3, br_wd3, core_stall, addr, data);
    end
    @(negedge clk);
    dbg_req = 1'b0;
    #1;
    tests_run++;
    if (dbg_ack !== 1'b1 || br_we !== 1'b1 || br_a3 !== 5'd7 || core_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL starve x%0d ack: ack=%b we=%b a3=%0d stall=%b, required 1 1 7 0",
               addr, dbg_ack, br_we, br_a3, core_stall);
    end
    core_we = 1'b0;
  endtask

  task automatic test_x0();
    @(negedge clk);
    core_we   = 1'b0;
    dbg_req   = 1'b1;
    dbg_wr    = 1'b1;
    dbg_addr  = '0;
    dbg_wdata = '1;
    #1;
    tests_run++;
    if (br_we !== 1'b0 || dbg_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL x0_dbg_write: we=%b ack=%b, required 0 0", br_we, dbg_ack);
    end
    @(negedge clk);
    dbg_req = 1'b0;
    #1;
    tests_run++;
    if (dbg_ack !== 1'b1) begin
      tests_failed++;
      $display("FAIL x0_dbg_ack: ack=%b, required 1", dbg_ack);
    end
    @(negedge clk);
    core_we  = 1'b1;
    core_a3  = '0;
    core_wd3 = '1;
    #1;
    tests_run++;
    if (br_we !== 1'b0 || core_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL x0_core_write: we=%b stall=%b, required 0 0", br_we, core_stall);
    end
    core_we = 1'b0;
    test_dbg_read(5'd0, 32'h0, "read_x0");
  endtask

  task automatic test_back_to_back();
    test_dbg_read(5'd5, 32'hDEAD_BEEF, "read_x5_again");
    test_dbg_write_free(5'd6, 32'h0000_CAFE);
    tests_run++;
    if (dbg_rdata !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL rdata_hold: rdata=%h, required deadbeef", dbg_rdata);
    end
    test_dbg_read(5'd6, 32'h0000_CAFE, "read_x6");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rst_n    = 1'b0;
    core_we  = 1'b1;
    core_a3  = 5'd3;
    core_wd3 = 32'hBAD0_BAD0;
    #1;
    tests_run++;
    if (dbg_rdata !== '0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_clears_rdata: rdata=%h busy=%b, required 0 1", dbg_rdata, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (9) @(negedge clk);
    #1;
    tests_run++;
    if (br_a3 !== 5'd10 || br_we !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_clear_pos: a3=%0d we=%b, required 10 1", br_a3, br_we);
    end
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if (br_we !== 1'b0 || busy !== 1'b1 || core_stall !== 1'b1 || dbg_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: we=%b busy=%b stall=%b ack=%b, required 0 1 1 0",
               br_we, busy, core_stall, dbg_ack);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_clear_sequence("restart");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_dbg_write_free(5'd5, 32'hDEAD_BEEF);
    test_dbg_read(5'd5, 32'hDEAD_BEEF, "read_x5");
    test_x0();
    test_dbg_read(5'd3, 32'h0, "read_x3_cleared");
    test_dbg_read(5'd31, 32'h0, "read_x31_cleared");
    test_starve(5'd9, 32'h0000_1234);
    test_starve(5'd10, 32'h0000_5678);
    test_dbg_read(5'd9, 32'h0000_1234, "read_x9");
    test_dbg_read(5'd10, 32'h0000_5678, "read_x10");
    test_back_to_back();
    test_dbg_read(5'd7, 32'h0000_0077, "read_x7");
    test_reset_mid();
    test_dbg_read(5'd9, 32'h0, "read_x9_recleared");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/br_port_ctrl.md
Name: br_port_ctrl

Overview:
- Controller placed in front of the BR register bank (2 read ports, 1 write port, 32x32).
- After reset, sequences a hardware clear of x1..x31. BR has no reset of its own.
- Then arbitrates BR's single write port, and the a2 read port, between the core and a debug/loader port using a req/ack handshake.
- Stalls the single-cycle core when it must take a port.

Parameters:
- NREG, 32, number of registers in BR.
- AW, 5, register address width.
- DW, 32, data width.
- STARVE_MAX, 4, consecutive cycles a pending debug write may lose to the core before it is forced.

Ports:
- clk  in  1  system clock; all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- core_we  in  1  core write-back enable.
- core_a3  in  AW  core write address (rd).
- core_wd3  in  DW  core write data.
- core_a2  in  AW  core read address (rs2).
- core_stall  out  1  core must hold PC/state this cycle.
- busy  out  1  clear sequence in progress.
- dbg_req  in  1  debug request; held stable until dbg_ack.
- dbg_wr  in  1  1 = write, 0 = read.
- dbg_addr  in  AW  debug register address.
- dbg_wdata  in  DW  debug write data.
- dbg_ack  out  1  one-cycle completion pulse.
- dbg_rdata  out  DW  read data; valid when dbg_ack=1; held until the next read.
- br_we  out  1  to BR we.
- br_a3  out  AW  to BR a3.
- br_wd3  out  DW  to BR wd3.
- br_a2  out  AW  to BR a2.
- br_rd2  in  DW  from BR rd2.

Behaviour:
- States: INIT, IDLE, ACK.
- Registers: clr_cnt[AW-1:0], starve_cnt (sized for 0..STARVE_MAX), dbg_rdata.

Reset:
- While rst_n=0: state=INIT, clr_cnt=1, starve_cnt=0, dbg_rdata=0.
- While rst_n=0 the outputs are gated: br_we=0, dbg_ack=0, core_stall=1, busy=1.
- Asserting rst_n low mid-operation aborts any transaction; no ack is issued.

INIT:
- Outputs: br_we=1, br_a3=clr_cnt, br_wd3=0, core_stall=1, busy=1. Core writes are dropped and dbg_req is ignored.
- clr_cnt increments each cycle. When clr_cnt==NREG-1 the next state is IDLE, giving exactly 31 write cycles.
- x0 is never written.

IDLE, default pass-through:
- br_we = core_we && core_a3!=0; br_a3=core_a3; br_wd3=core_wd3; br_a2=core_a2; core_stall=0.

IDLE, dbg_req && !dbg_wr (debug read):
- br_a2=dbg_addr and core_stall=1 this cycle.
- The core write is masked (br_we=0) so the stalled instruction does not double-execute.
- dbg_rdata <= br_rd2; next state ACK.
- Reading x0 returns BR's content, which is 0.

IDLE, dbg_req && dbg_wr && !core_we (free port):
- br_we=(dbg_addr!=0), br_a3=dbg_addr, br_wd3=dbg_wdata; starve_cnt<=0; next state ACK.

IDLE, dbg_req && dbg_wr && core_we && starve_cnt<STARVE_MAX (core wins):
- Core is passed through; starve_cnt++.

IDLE, dbg_req && dbg_wr && core_we && starve_cnt==STARVE_MAX (forced):
- core_stall=1, core write masked, debug write issued as above; starve_cnt<=0; next state ACK.

ACK:
- dbg_ack=1 for exactly one cycle; core is passed through as in IDLE; next state IDLE.
- dbg_req is not sampled in ACK. Minimum transaction spacing is 2 cycles.

Other rules:
- Write to x0 from either source: no br_we; a debug write to x0 still acks.
- A debug write to the same register as a simultaneous core write cannot occur: debug writes only when the core write is absent or masked.
- dbg_req dropped before ack: protocol violation; behaviour is undefined and need not be checked.
- BR writes occur at the posedge following the cycle in which br_we is asserted.
- Debug write latency: 1 cycle from acceptance to ack. Debug read latency: 1 cycle.

Decomposition:
- Shared br_defs package/header: NREG, AW, DW, the state encoding (INIT=2'd0, IDLE=2'd1, ACK=2'd2), and the x0 address constant.
- No sub-module: the FSM and counters fit in one module of roughly 150-200 lines.

Test Plan:
- Reset release -> br_we=1 for 31 cycles, br_a3 running 1..31, br_wd3=0, busy=1 and core_stall=1 throughout; busy=0 on cycle 32.
- After init, core_we=0, debug write x5=0xDEADBEEF -> br_we=1, br_a3=5 in the accept cycle, dbg_ack the next cycle. Then debug read x5 -> core_stall=1 for one cycle, dbg_ack with dbg_rdata=0xDEADBEEF.
- core_we=1 held continuously (core_a3=7), debug write x9=0x1234 -> core writes x7 for 4 cycles. On the 5th cycle core_stall=1, br_a3=9, br_wd3=0x1234. dbg_ack follows.
- Debug write x0=0xFFFFFFFF -> br_we stays 0, dbg_ack pulses; a later debug read of x0 returns 0.
- core_we=1 with core_a3=3 during INIT -> no br_a3=3 write with nonzero data; x3 reads 0 after init.
- rst_n pulled low while clr_cnt=10 -> br_we=0 immediately (asynchronous). On release, clearing restarts at br_a3=1 and runs 31 cycles.
